// File: rtl/masked_sbox_arbiter.sv
// Two-port round-robin front end for a shared, fixed-latency masked AES S-box.
// Tracks owner/tag of every in-flight byte and requests fresh randomness while the gadgets hold data.
module masked_sbox_arbiter #(
    parameter int NUM_SHARES = 2,
    parameter int LATENCY    = 3,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic [1:0]                  in_req_valid,
    output logic [1:0]                  out_req_ready,
    input  logic [2*NUM_SHARES*8-1:0]   in_req_data,
    input  logic [2*TAG_WIDTH-1:0]      in_req_tag,
    output logic [NUM_SHARES*8-1:0]     out_sbox_in,
    input  logic [NUM_SHARES*8-1:0]     in_sbox_out,
    output logic                        out_rand_step,
    output logic                        out_resp_valid,
    output logic                        out_resp_owner,
    output logic [TAG_WIDTH-1:0]        out_resp_tag,
    output logic [NUM_SHARES*8-1:0]     out_resp_data,
    output logic                        out_idle
);

    localparam int DW = NUM_SHARES * 8;
    localparam int CW = $clog2(LATENCY + 1);

    logic                 last_q, last_d;
    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [LATENCY-1:0]   own_q, own_d;
    logic [TAG_WIDTH-1:0] tag_q [LATENCY];
    logic [TAG_WIDTH-1:0] tag_d [LATENCY];
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           grant_s;
    logic                 xfer_s;
    logic                 gnt_idx_s;
    logic                 resp_s;

    // Round-robin grant; nothing is granted while reset is held.
    always_comb begin
        grant_s = 2'b00;
        if (in_reset) begin
            case (in_req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign xfer_s    = |grant_s;
    assign gnt_idx_s = grant_s[1];
    assign resp_s    = vld_q[LATENCY-1];

    // Issue mux: only the granted port's shares ever reach the S-box, zeros otherwise.
    always_comb begin
        out_sbox_in = {DW{1'b0}};
        if (grant_s[0]) begin
            out_sbox_in = in_req_data[DW-1:0];
        end else if (grant_s[1]) begin
            out_sbox_in = in_req_data[2*DW-1:DW];
        end else begin
            out_sbox_in = {DW{1'b0}};
        end
    end

    // Next state: tracking shift register, grant pointer and in-flight counter.
    always_comb begin
        last_d   = last_q;
        vld_d    = {LATENCY{1'b0}};
        own_d    = {LATENCY{1'b0}};
        cnt_d    = cnt_q;
        vld_d[0] = xfer_s;
        own_d[0] = gnt_idx_s;
        tag_d[0] = {TAG_WIDTH{1'b0}};
        if (xfer_s) begin
            last_d   = gnt_idx_s;
            tag_d[0] = gnt_idx_s ? in_req_tag[2*TAG_WIDTH-1:TAG_WIDTH]
                                 : in_req_tag[TAG_WIDTH-1:0];
        end else begin
            last_d = last_q;
        end
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        if (xfer_s && !resp_s) begin
            cnt_d = cnt_q + CW'(1'b1);
        end else if (!xfer_s && resp_s) begin
            cnt_d = cnt_q - CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            last_q <= 1'b1;
            vld_q  <= {LATENCY{1'b0}};
            own_q  <= {LATENCY{1'b0}};
            cnt_q  <= {CW{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= {TAG_WIDTH{1'b0}};
            end
        end else begin
            last_q <= last_d;
            vld_q  <= vld_d;
            own_q  <= own_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_req_ready  = grant_s;
    assign out_resp_valid = resp_s & in_reset;
    assign out_resp_owner = own_q[LATENCY-1];
    assign out_resp_tag   = tag_q[LATENCY-1];
    assign out_resp_data  = in_sbox_out & {DW{out_resp_valid}};
    // Randomness must advance on every cycle a masked value sits in the gadgets.
    assign out_rand_step  = in_reset & (xfer_s | (|vld_q));
    assign out_idle       = ~in_reset | ((cnt_q == {CW{1'b0}}) & ~xfer_s);

    masked_sbox_arbiter_chk #(
        .LATENCY (LATENCY),
        .CW      (CW)
    ) u_chk (
        .clk_i   (in_clock),
        .rst_n_i (in_reset),
        .cnt_i   (cnt_q),
        .vld_i   (vld_q),
        .valid_i (in_req_valid),
        .ready_i (grant_s)
    );

endmodule

// Invariants of the arbiter: counter bound/consistency and handshake legality.
module masked_sbox_arbiter_chk #(
    parameter int LATENCY = 3,
    parameter int CW      = 2
) (
    input logic               clk_i,
    input logic               rst_n_i,
    input logic [CW-1:0]      cnt_i,
    input logic [LATENCY-1:0] vld_i,
    input logic [1:0]         valid_i,
    input logic [1:0]         ready_i
);

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        int'(cnt_i) <= LATENCY);
    a_cnt_pop: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        int'(cnt_i) == $countones(vld_i));
    a_onehot: assert property (@(posedge clk_i) $onehot0(ready_i));
    a_rdy_vld: assert property (@(posedge clk_i) (ready_i & ~valid_i) == 2'b00);

endmodule

// File: tb/tb_masked_sbox_arbiter.sv
// Directed bench for masked_sbox_arbiter (LATENCY=3, NUM_SHARES=2, TAG_WIDTH=4).
module tb_masked_sbox_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [31:0] data;
    logic [7:0]  tags;
    logic [15:0] sbin;
    logic [15:0] sbout;
    logic        rs;
    logic        rv;
    logic        ro;
    logic [3:0]  rt;
    logic [15:0] rd;
    logic        idle;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    masked_sbox_arbiter #(
        .NUM_SHARES (2),
        .LATENCY    (3),
        .TAG_WIDTH  (4)
    ) dut (
        .in_clock       (clk),
        .in_reset       (rst_n),
        .in_req_valid   (vld),
        .out_req_ready  (rdy),
        .in_req_data    (data),
        .in_req_tag     (tags),
        .out_sbox_in    (sbin),
        .in_sbox_out    (sbout),
        .out_rand_step  (rs),
        .out_resp_valid (rv),
        .out_resp_owner (ro),
        .out_resp_tag   (rt),
        .out_resp_data  (rd),
        .out_idle       (idle)
    );

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_all(input string nm, input logic [1:0] e_rdy, input logic e_rv,
                           input logic e_ro, input logic [3:0] e_rt, input logic [15:0] e_rd,
                           input logic e_rs, input logic e_idle, input logic [15:0] e_sbin);
        #2;
        chk({nm, ".ready"}, {30'd0, rdy}, {30'd0, e_rdy});
        chk({nm, ".resp_valid"}, {31'd0, rv}, {31'd0, e_rv});
        chk({nm, ".resp_owner"}, {31'd0, ro}, {31'd0, e_ro});
        chk({nm, ".resp_tag"}, {28'd0, rt}, {28'd0, e_rt});
        chk({nm, ".resp_data"}, {16'd0, rd}, {16'd0, e_rd});
        chk({nm, ".rand_step"}, {31'd0, rs}, {31'd0, e_rs});
        chk({nm, ".idle"}, {31'd0, idle}, {31'd0, e_idle});
        chk({nm, ".sbox_in"}, {16'd0, sbin}, {16'd0, e_sbin});
    endtask

    initial begin
        logic [1:0]  er;
        logic        erv;
        logic        ero;
        logic [3:0]  ert;
        logic [15:0] erd;
        logic [15:0] esb;
        int          j;

        rst_n = 1'b0; vld = 2'b00; data = 32'd0; tags = 8'd0; sbout = 16'd0;
        nxt();
        vld = 2'b11; data = 32'h1111_2222; tags = 8'h21;
        exp_all("reset", 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 16'h0000);

        // Single port-0 byte: tag 5, shares {0x3C, 0x5F}.
        nxt();
        rst_n = 1'b1; vld = 2'b01; tags = 8'h05; data = 32'h0000_5F3C;
        exp_all("single.c1", 2'b01, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h5F3C);
        nxt();
        vld = 2'b00; data = 32'd0; tags = 8'd0;
        exp_all("single.c2", 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        nxt();
        exp_all("single.c3", 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        nxt();
        sbout = 16'hC3E7;
        exp_all("single.c4", 2'b00, 1'b1, 1'b0, 4'h5, 16'hC3E7, 1'b1, 1'b0, 16'h0000);

        // Quiet period: stray data on the bus must not leak through.
        for (int i = 0; i < 5; i++) begin
            nxt();
            sbout = 16'hFFFF; data = 32'hDEAD_BEEF; tags = 8'h9A;
            exp_all("quiet", 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 16'h0000);
        end

        // Reset restores pointer; then continuous two-port contention.
        nxt();
        rst_n = 1'b0; vld = 2'b00;
        exp_all("rst2", 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 16'h0000);
        nxt();
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            vld   = (k < 10) ? 2'b11 : 2'b00;
            tags  = {4'(2 * k + 1), 4'(2 * k)};
            data  = {16'hB000 | 16'(k), 16'hA000 | 16'(k)};
            sbout = 16'h5000 | 16'(k);
            if (k < 10) begin
                er  = (k % 2 == 0) ? 2'b01 : 2'b10;
                esb = (k % 2 == 0) ? (16'hA000 | 16'(k)) : (16'hB000 | 16'(k));
            end else begin
                er  = 2'b00;
                esb = 16'h0000;
            end
            j = k - 3;
            if (j >= 0 && j < 10) begin
                erv = 1'b1;
                ero = 1'(j % 2);
                ert = (j % 2 == 0) ? 4'(2 * j) : 4'(2 * j + 1);
                erd = 16'h5000 | 16'(k);
            end else begin
                erv = 1'b0; ero = 1'b0; ert = 4'h0; erd = 16'h0000;
            end
            exp_all($sformatf("rr%0d", k), er, erv, ero, ert, erd, 1'(k <= 12), 1'(k > 12), esb);
            nxt();
        end

        // Port 1 alone is served every cycle; port 0 joining then wins.
        for (int i = 0; i < 10; i++) begin
            vld = 2'b10; tags = {4'(i), 4'hF}; data = {16'hB000 | 16'(i), 16'hA000 | 16'(i)};
            #2;
            chk($sformatf("p1only%0d.ready", i), {30'd0, rdy}, 32'd2);
            chk($sformatf("p1only%0d.sbox_in", i), {16'd0, sbin}, {16'd0, 16'hB000 | 16'(i)});
            nxt();
        end
        vld = 2'b11;
        #2;
        chk("join.ready", {30'd0, rdy}, 32'd1);
        chk("join.sbox_in", {16'd0, sbin}, {16'd0, 16'hA009});
        nxt();
        #2;
        chk("join2.ready", {30'd0, rdy}, 32'd2);
        nxt();
        vld = 2'b00;
        for (int i = 0; i < 4; i++) nxt();
        #2;
        chk("drained.idle", {31'd0, idle}, 32'd1);

        // Two bytes in flight (port 1 then port 0), then reset mid-operation.
        nxt();
        vld = 2'b10; tags = 8'h2F;
        #2;
        chk("flt1.ready", {30'd0, rdy}, 32'd2);
        nxt();
        vld = 2'b01; tags = 8'hF1;
        #2;
        chk("flt2.ready", {30'd0, rdy}, 32'd1);
        nxt();
        rst_n = 1'b0; vld = 2'b11;
        exp_all("midrst", 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 16'h0000);
        nxt();
        rst_n = 1'b1; vld = 2'b00; sbout = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            exp_all($sformatf("postrst%0d", i), 2'b00, 1'b0, 1'b0, 4'h0, 16'h0000,
                    1'b0, 1'b1, 16'h0000);
            nxt();
        end
        vld = 2'b11;
        #2;
        chk("postrst.first_grant", {30'd0, rdy}, 32'd1);
        nxt();
        vld = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
